// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl: sequencing controller for the ASCON-128 permutator_xor datapath.
// One permutation round per clock. Runs initialisation, AD absorption,
// plaintext encryption and finalisation, with a valid/ready host handshake
// for each 64-bit block. The handshake cycle of every block is also the first
// round of that block, so the transfer-qualified strobes follow data_valid_i
// combinationally while everything else is registered.
module ascon_fsm_ctrl #(
  parameter int unsigned NB_AD_BLOCKS = 1,
  parameter int unsigned NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       input_select_o,
  output logic       xorup_select_o,
  output logic       up_key_o,
  output logic [1:0] xordn_select_o,
  output logic       ena_reg_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RND_W = 4;
  localparam int unsigned XDN_W = 2;

  localparam logic [CNT_W-1:0] LAST_AD  = CNT_W'(NB_AD_BLOCKS - 1);
  localparam logic [CNT_W-1:0] LAST_PT  = CNT_W'(NB_PT_BLOCKS - 1);
  localparam logic [CNT_W-1:0] BLK_MAX  = CNT_W'(14);
  localparam logic [CNT_W-1:0] INIT_END = CNT_W'(11);
  localparam logic [CNT_W-1:0] BLK_END  = CNT_W'(4);   // 5 registered rounds after the transfer round
  localparam logic [CNT_W-1:0] FIN_END  = CNT_W'(10);  // 11 registered rounds after the transfer round

  localparam logic [XDN_W-1:0] XDN_NONE = XDN_W'(0);
  localparam logic [XDN_W-1:0] XDN_KEY  = XDN_W'(1);
  localparam logic [XDN_W-1:0] XDN_DSEP = XDN_W'(2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_AD_WAIT,
    S_AD_RND,
    S_PT_WAIT,
    S_PT_RND,
    S_FIN_WAIT,
    S_FINAL,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             ready;
    logic [RND_W-1:0] round;
    logic             in_sel;
    logic [XDN_W-1:0] xordn;
    logic             ena;
    logic             tag_valid;
    logic             busy;
    logic             done;
  } moore_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] blk_inc;
  moore_t           out_q, out_d;
  logic             xfer;

  // Host transfer: only possible while a WAIT state has ready asserted.
  assign xfer    = out_q.ready & data_valid_i;
  assign blk_inc = (blk_q == BLK_MAX) ? blk_q : blk_q + CNT_W'(1);

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          rnd_d   = '0;
        end
      end
      S_INIT: begin
        if (rnd_q == INIT_END) begin
          state_d = S_AD_WAIT;
          rnd_d   = '0;
          blk_d   = '0;
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      S_AD_WAIT: begin
        if (xfer) begin
          state_d = S_AD_RND;
          rnd_d   = '0;
        end
      end
      S_AD_RND: begin
        if (rnd_q == BLK_END) begin
          rnd_d = '0;
          if (blk_q == LAST_AD) begin
            blk_d   = '0;
            state_d = (NB_PT_BLOCKS == 1) ? S_FIN_WAIT : S_PT_WAIT;
          end else begin
            blk_d   = blk_inc;
            state_d = S_AD_WAIT;
          end
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      S_PT_WAIT: begin
        if (xfer) begin
          state_d = S_PT_RND;
          rnd_d   = '0;
        end
      end
      S_PT_RND: begin
        if (rnd_q == BLK_END) begin
          rnd_d   = '0;
          blk_d   = blk_inc;
          state_d = (blk_inc == LAST_PT) ? S_FIN_WAIT : S_PT_WAIT;
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      S_FIN_WAIT: begin
        if (xfer) begin
          state_d = S_FINAL;
          rnd_d   = '0;
        end
      end
      S_FINAL: begin
        if (rnd_q == FIN_END) begin
          state_d = S_DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rnd_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = '0;
        blk_d   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    out_d = '0;
    case (state_d)
      S_INIT: begin
        out_d.round  = rnd_d;
        out_d.in_sel = (rnd_d != '0);
        out_d.xordn  = (rnd_d == INIT_END) ? XDN_KEY : XDN_NONE;
        out_d.ena    = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_AD_WAIT, S_PT_WAIT: begin
        out_d.ready  = 1'b1;
        out_d.round  = RND_W'(6);
        out_d.in_sel = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_FIN_WAIT: begin
        out_d.ready  = 1'b1;
        out_d.round  = RND_W'(0);
        out_d.in_sel = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_AD_RND: begin
        out_d.round  = RND_W'(7) + rnd_d;
        out_d.in_sel = 1'b1;
        out_d.xordn  = (rnd_d == BLK_END && blk_d == LAST_AD) ? XDN_DSEP : XDN_NONE;
        out_d.ena    = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_PT_RND: begin
        out_d.round  = RND_W'(7) + rnd_d;
        out_d.in_sel = 1'b1;
        out_d.ena    = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_FINAL: begin
        out_d.round  = RND_W'(1) + rnd_d;
        out_d.in_sel = 1'b1;
        out_d.xordn  = (rnd_d == FIN_END) ? XDN_KEY : XDN_NONE;
        out_d.ena    = 1'b1;
        out_d.busy   = 1'b1;
      end
      S_DONE: begin
        out_d.in_sel    = 1'b1;
        out_d.tag_valid = 1'b1;
        out_d.busy      = 1'b1;
        out_d.done      = 1'b1;
      end
      default: out_d = '0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      blk_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
    end
  end

  assign data_ready_o   = out_q.ready;
  assign round_o        = out_q.round;
  assign input_select_o = out_q.in_sel;
  assign xordn_select_o = out_q.xordn;
  assign ena_reg_o      = out_q.ena | xfer;
  assign xorup_select_o = xfer;
  assign cipher_valid_o = xfer & ((state_q == S_PT_WAIT) || (state_q == S_FIN_WAIT));
  assign up_key_o       = xfer & (state_q == S_FIN_WAIT);
  assign tag_valid_o    = out_q.tag_valid;
  assign busy_o         = out_q.busy;
  assign done_o         = out_q.done;

endmodule
